// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch-stage bus: ROM port, decoder handshake, redirect inputs
interface inst_fetch_queue_if #(
    parameter int PC_W   = 6,
    parameter int INST_W = 16,
    parameter int OFF_W  = 5
);
    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   inst_pc;
    logic [1:0]        redirect_sel;
    logic [PC_W-1:0]   jump_address;
    logic [OFF_W-1:0]  branch_address;
    logic [PC_W-1:0]   branch_base;
    logic [2:0]        q_count;

    modport master (
        output imem_en, imem_addr, inst_valid, inst_out, inst_pc, q_count,
        input  imem_rdata, inst_ready, redirect_sel, jump_address, branch_address, branch_base
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst_out, inst_pc, q_count,
        output imem_rdata, inst_ready, redirect_sel, jump_address, branch_address, branch_base
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - PC owner, 1-cycle ROM reader and instruction FIFO with redirect flush
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 6,
    parameter int INST_W = 16,
    parameter int OFF_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PC_W+INST_W-1:0] entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   pend_pc;
    logic [PC_W-1:0]   target;
    logic              inflight;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              redirect;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;

    always_comb begin
        redirect   = (bus.redirect_sel == 2'b01) || (bus.redirect_sel == 2'b10);
        target     = (bus.redirect_sel == 2'b01) ? bus.jump_address
                                                 : bus.branch_base + PC_W'(bus.branch_address);
        // The in-flight read is counted so its return always has a free slot.
        occ        = {1'b0, count} + (CW+1)'(inflight);
        issue      = !rst && !redirect && (occ < (CW+1)'(DEPTH));
        push       = inflight && !redirect;
        head_valid = (count != '0);
        pop        = head_valid && bus.inst_ready && !redirect;
        head       = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= '0;
            pend_pc  <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
                pend_pc  <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= {pend_pc, bus.imem_rdata};
    end

    assign bus.imem_en    = issue;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = head_valid;
    assign bus.inst_out   = head_valid ? head[INST_W-1:0] : '0;
    assign bus.inst_pc    = head_valid ? head[PC_W+INST_W-1:INST_W] : '0;
    assign bus.q_count    = 3'(count);
endmodule
